// File: rtl/aes_key_expansion_reverse_seq_pkg.sv
// Shared types, round constants and GF(2^8) helpers for the inverse AES key schedule iterator.
// The S-box is built from the field inverse plus the affine map, so no lookup table is stored.
package aes_key_pkg;

   localparam int LAST_ROUND_128 = 10;
   localparam int LAST_ROUND_256 = 14;

   // Entry [0] is Rcon[1].
   localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   typedef enum logic {AES128 = 1'b0, AES256 = 1'b1} key_len_e;
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse (and maps 0 to 0).
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] round);
      if (round >= 4'd1 && round <= 4'd10) return RCON[round - 4'd1];
      return 8'h00;
   endfunction

endpackage

// File: rtl/aes_key_expansion_reverse_seq_if.sv
// Start/key-load and round-key stream bundle; slave side is the key schedule iterator.
interface aes_key_expansion_reverse_seq_if;
   logic         start;
   logic         key_len_256;
   logic [255:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_index;
   logic         done;

   modport master (
      output start, key_len_256, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_index, done
   );

   modport slave (
      input  start, key_len_256, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_index, done
   );
endinterface

// File: rtl/aes_key_expansion_reverse_seq_sub_word.sv
// SubWord with optional RotWord and Rcon XOR on the top byte; purely combinational.
module aes_key_sub_word
   import aes_key_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic        rot_en_i,
   input  logic [7:0]  rcon_i,
   output logic [31:0] word_o
);
   logic [31:0] rot;
   logic [31:0] sub;

   always_comb begin
      rot = rot_en_i ? {word_i[23:0], word_i[31:24]} : word_i;
      sub = '0;
      for (int b = 0; b < 4; b++) sub[8*b +: 8] = sbox(rot[8*b +: 8]);
      word_o = sub ^ {rcon_i, 24'h0};
   end
endmodule

// File: rtl/aes_key_expansion_reverse_seq.sv
// Streams AES-128/256 round keys last-to-first from the final round key(s), one per rk handshake.
// Latency: first key the cycle after start; rk_ready low stalls with outputs and state frozen.
module aes_key_expansion_reverse_seq
   import aes_key_pkg::*;
#(
   parameter bit SUPPORT_256 = 1'b1
) (
   input logic                            clk,
   input logic                            rst,
   aes_key_expansion_reverse_seq_if.slave ks
);
   state_e       state_q, state_d;
   key_len_e     mode_q, mode_d;
   logic [127:0] hi_q, hi_d;
   logic [127:0] lo_q, lo_d;
   logic [3:0]   idx_q, idx_d;
   logic         done_q, done_d;
   logic         hs;
   logic [31:0]  sw_in, sw_out;
   logic         sw_rot;
   logic [7:0]   sw_rcon;
   logic [127:0] rev;

   assign hs = (state_q == EMIT) && ks.rk_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (ks.start) state_d = EMIT;
         EMIT: if (hs && idx_q == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ks.busy     = (state_q == EMIT);
      ks.rk_valid = (state_q == EMIT);
      ks.rk_out   = (state_q == EMIT) ? hi_q : '0;
      ks.rk_index = (state_q == EMIT) ? idx_q : '0;
      ks.done     = done_q;
   end

   // AES-256 feeds l3 (rotated+Rcon only on even rounds); AES-128 feeds the recovered w3.
   always_comb begin
      if (mode_q == AES256) begin
         sw_in   = lo_q[31:0];
         sw_rot  = ~idx_q[0];
         sw_rcon = idx_q[0] ? 8'h00 : rcon_of({1'b0, idx_q[3:1]});
      end else begin
         sw_in   = hi_q[31:0] ^ hi_q[63:32];
         sw_rot  = 1'b1;
         sw_rcon = rcon_of(idx_q);
      end
   end

   aes_key_sub_word u_sub_word (
      .word_i   (sw_in),
      .rot_en_i (sw_rot),
      .rcon_i   (sw_rcon),
      .word_o   (sw_out)
   );

   assign rev = {hi_q[127:96] ^ sw_out,
                 hi_q[95:64]  ^ hi_q[127:96],
                 hi_q[63:32]  ^ hi_q[95:64],
                 hi_q[31:0]   ^ hi_q[63:32]};

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      idx_d  = idx_q;
      mode_d = mode_q;
      done_d = 1'b0;
      if (state_q == IDLE && ks.start) begin
         mode_d = (SUPPORT_256 && ks.key_len_256) ? AES256 : AES128;
         hi_d   = ks.key_in[127:0];
         lo_d   = SUPPORT_256 ? ks.key_in[255:128] : '0;
         idx_d  = (mode_d == AES256) ? 4'(LAST_ROUND_256) : 4'(LAST_ROUND_128);
      end else if (hs) begin
         idx_d = idx_q - 4'd1;
         if (idx_q == 4'd0) begin
            done_d = 1'b1;
         end else if (mode_q == AES256) begin
            hi_d = lo_q;
            if (idx_q >= 4'd2) lo_d = rev;
         end else begin
            hi_d = rev;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         idx_q  <= '0;
         mode_q <= AES128;
         done_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         idx_q  <= idx_d;
         mode_q <= mode_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_aes_key_expansion_reverse_seq.sv
// Bench: forward key expansion model fills a scoreboard that the round-key stream is checked against.
module tb_aes_key_expansion_reverse_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [127:0] exp_key_q[$];
   logic [3:0]   exp_idx_q[$];
   logic [127:0] rk_model [0:14];

   logic [2047:0] sbox_bits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_key_expansion_reverse_seq_if dif();
   aes_key_expansion_reverse_seq_if dif128();

   aes_key_expansion_reverse_seq #(.SUPPORT_256(1'b1)) dut    (.clk(clk), .rst(rst), .ks(dif));
   aes_key_expansion_reverse_seq #(.SUPPORT_256(1'b0)) dut128 (.clk(clk), .rst(rst), .ks(dif128));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_bits[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [7:0] rc(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 1; i < n; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
      return r;
   endfunction

   // Forward FIPS-197 expansion; key word 0 sits at key[255:224].
   task automatic expand(input logic [255:0] key, input bit is256);
      logic [31:0] w [0:59];
      logic [31:0] t;
      int nk;
      int nr;
      nk = is256 ? 8 : 4;
      nr = is256 ? 14 : 10;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(i/nk), 24'h0};
         else if (nk == 8 && i % 8 == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_exp(input int nr);
      for (int r = nr; r >= 0; r--) begin
         exp_key_q.push_back(rk_model[r]);
         exp_idx_q.push_back(4'(r));
      end
   endtask

   task automatic do_start(input logic [255:0] key, input bit len256);
      dif.key_in      = key;
      dif.key_len_256 = len256;
      dif.start       = 1'b1;
      @(posedge clk); #1;
      dif.start       = 1'b0;
      dif.key_in      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      dif.key_len_256 = ~len256;
      chk("busy_after_start", 128'(dif.busy), 128'(1));
   endtask

   // exp_k < 0 skips the cycle-count check (randomised backpressure).
   task automatic wait_done(input int exp_k, input bit rnd, input string tag);
      int k;
      bit seen;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 400) begin
         if (dif.done) begin
            seen = 1'b1;
         end else begin
            if (rnd) begin
               dif.rk_ready = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 3) == 0) begin
                  dif.start       = 1'b1;
                  dif.key_in      = {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
                  dif.key_len_256 = 1'($urandom_range(0, 1));
               end else begin
                  dif.start = 1'b0;
               end
            end
            @(posedge clk); #1;
            k++;
         end
      end
      dif.start    = 1'b0;
      dif.rk_ready = 1'b1;
      chk({tag, "_done_seen"}, 128'(seen), 128'(1));
      if (exp_k >= 0) chk({tag, "_done_cycle"}, 128'(k), 128'(exp_k));
      chk({tag, "_busy_at_done"}, 128'(dif.busy), 128'(0));
      chk({tag, "_keys_left"}, 128'(exp_key_q.size()), 128'(0));
   endtask

   // Scoreboard: while valid, the head entry must be presented (also during stalls).
   always @(negedge clk) begin
      if (!rst && dif.rk_valid) begin
         if (exp_key_q.size() == 0) begin
            chk("sb_unexpected_valid", 128'(dif.rk_valid), 128'(0));
         end else begin
            chk("sb_rk_out", dif.rk_out, exp_key_q[0]);
            chk("sb_rk_index", 128'(dif.rk_index), 128'(exp_idx_q[0]));
            if (dif.rk_ready) begin
               void'(exp_key_q.pop_front());
               void'(exp_idx_q.pop_front());
            end
         end
      end
   end

   initial begin
      int k;
      dif.start = 1'b0;  dif.key_len_256 = 1'b0;  dif.key_in = '0;  dif.rk_ready = 1'b0;
      dif128.start = 1'b0;  dif128.key_len_256 = 1'b0;  dif128.key_in = '0;  dif128.rk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 128'(dif.busy), 128'(0));
      chk("rst_rk_valid", 128'(dif.rk_valid), 128'(0));
      chk("rst_rk_out", dif.rk_out, 128'(0));
      chk("rst_rk_index", 128'(dif.rk_index), 128'(0));
      chk("rst_done", 128'(dif.done), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // AES-128, FIPS-197 key 000102..0f
      expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
      push_exp(10);
      dif.rk_ready = 1'b1;
      do_start({128'h0, 128'h13111d7fe3944a17f307a78b4d2b30c5}, 1'b0);
      wait_done(11, 1'b0, "aes128_a");

      // AES-128, key 2b7e..; started in the done cycle of the previous schedule
      expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
      push_exp(10);
      do_start({128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, 1'b0);
      wait_done(11, 1'b0, "aes128_b");

      // AES-256, key 000102..1f
      expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
      push_exp(14);
      do_start({128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36}, 1'b1);
      wait_done(15, 1'b0, "aes256");

      // AES-256 with random backpressure and stray starts while busy
      push_exp(14);
      do_start({128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36}, 1'b1);
      wait_done(-1, 1'b1, "aes256_rnd");

      // Reset mid-schedule at rk_index 5
      expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
      push_exp(10);
      @(posedge clk); #1;
      do_start({128'h0, 128'h13111d7fe3944a17f307a78b4d2b30c5}, 1'b0);
      k = 0;
      while (dif.rk_index != 4'd5 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("abort_reached_idx5", 128'(dif.rk_index), 128'(5));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 128'(dif.busy), 128'(0));
      chk("abort_rk_valid", 128'(dif.rk_valid), 128'(0));
      chk("abort_rk_out", dif.rk_out, 128'(0));
      chk("abort_rk_index", 128'(dif.rk_index), 128'(0));
      chk("abort_done", 128'(dif.done), 128'(0));
      exp_key_q.delete();
      exp_idx_q.delete();
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_done", 128'(dif.done), 128'(0));
      end
      push_exp(10);
      do_start({128'h0, 128'h13111d7fe3944a17f307a78b4d2b30c5}, 1'b0);
      wait_done(11, 1'b0, "after_abort");

      // SUPPORT_256=0 instance ignores key_len_256 and the upper key half
      dif128.rk_ready    = 1'b1;
      dif128.key_len_256 = 1'b1;
      dif128.key_in      = {128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      dif128.start       = 1'b1;
      @(posedge clk); #1;
      dif128.start = 1'b0;
      for (int r = 10; r >= 0; r--) begin
         chk("s128_valid", 128'(dif128.rk_valid), 128'(1));
         chk("s128_index", 128'(dif128.rk_index), 128'(r));
         chk("s128_key", dif128.rk_out, rk_model[r]);
         @(posedge clk); #1;
      end
      chk("s128_done", 128'(dif128.done), 128'(1));
      chk("s128_busy", 128'(dif128.busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
